if_id_skid_reg: RTL and testbench
=================================

# if_id_skid_reg

Parametrised IF/ID pipeline stage register that sits between the fetch stage and decode. It carries the PC, the instruction and an opaque branch-predictor metadata bundle (YAGS/PHT prediction, T/NT array indices, hit flags) from IF to ID. It replaces fixed-width stall/flush registers with a valid/ready handshake, optional two-entry skid buffering, bubble-instruction insertion and a saturating squash counter.

## Interface
- PC_W, 32, PC width
- INSTR_W, 32, instruction width
- META_W, 26, predictor metadata width; content is opaque to this block
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- BUBBLE_INSTR, 32'h0000_0013, instruction driven on out_instr while out_valid=0 (RV32I NOP)
- CNT_W, 16, squash counter width

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, asynchronous active-low reset
- flush  in  1  squash all held entries; driver ORs YAGS conflict and EX jump redirect
- in_valid  in  1  IF offers an entry
- in_ready  out  1  stage accepts an entry
- in_pc  in  PC_W  fetch PC
- in_instr  in  INSTR_W  fetched instruction
- in_meta  in  META_W  predictor metadata
- out_valid  out  1  entry presented to ID
- out_ready  in  1  ID accepts (deasserted on load-use stall)
- out_pc  out  PC_W
- out_instr  out  INSTR_W
- out_meta  out  META_W
- occupancy  out  2  valid entries held (0..2; max 1 when SKID=0)
- squash_cnt  out  CNT_W  saturating count of valid entries killed by flush

## Operation
- Main register M drives the outputs; skid register S exists only when SKID=1.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- While M is invalid: out_pc=0, out_meta=0, out_instr=BUBBLE_INSTR.
- States for SKID=1: EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid).
  - EMPTY: in_fire -> M<=in, go to ONE.
  - ONE: in_fire & out_fire -> M<=in, stay in ONE. out_fire only -> EMPTY. in_fire only -> S<=in, go to FULL. Neither -> hold.
  - FULL: in_ready=0. out_fire -> M<=S, go to ONE. Otherwise hold.
- SKID=1: in_ready is a registered value equal to !S.valid; no combinational path from out_ready.
- SKID=0: states are EMPTY and ONE only; in_ready = !M.valid | out_ready (combinational).
- flush has priority over every other event:
  - M and S are invalidated next cycle; the in_fire in the flush cycle is discarded.
  - in_ready is 1 the following cycle.
  - squash_cnt += number of valid entries (M.valid + S.valid) in the flush cycle, saturating at 2^CNT_W-1; a discarded input is not counted.
- Entries leave in strict FIFO order. Payload passes bit-exact, no reordering of meta fields.
- occupancy = M.valid + S.valid.

## Timing
- Reset (asynchronous assert, synchronous to clk on release) forces:
  - out_valid=0, out_pc=0, out_instr=BUBBLE_INSTR, out_meta=0
  - occupancy=0, squash_cnt=0
  - in_ready=1 (SKID=1); in_ready=1 (SKID=0, since M is invalid)
- Latency: in_fire at edge N -> out_valid with that payload after edge N, visible in cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- out_ready deasserted with SKID=1: one more input is accepted into S, then in_ready=0 from the next cycle.
- Reset asserted mid-transfer drops all entries immediately. No partial state survives reset.
- flush together with out_fire: the entry counts as squashed, not delivered. ID must ignore out_* in a flush cycle; its own flush covers this.

## Test plan
- Reset, then stream 8 entries (PC 0x0,0x4,...,0x1C) with out_ready=1 -> outputs in order, 1-cycle latency, occupancy stays 1, squash_cnt=0.
- SKID=1, ONE with PC 0x100 held; deassert out_ready with in_valid=1 PC 0x104 -> occupancy=2, in_ready=0 next cycle. Reassert -> 0x100 then 0x104, no loss or duplication.
- FULL, flush=1 with in_valid=1 PC 0x200 -> out_valid=0, out_instr=0x13, occupancy=0, squash_cnt+=2, PC 0x200 never appears.
- CNT_W=2, flush 3 times with occupancy 2 each time -> squash_cnt saturates at 3.
- SKID=0, out_ready=0 with M valid -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally and simultaneous replacement occurs.
- Assert reset asynchronously between edges while FULL -> outputs go to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline stage register with a valid/ready handshake.
// Carries PC, instruction and opaque predictor metadata from fetch to decode.
// SKID=1 adds a second (skid) entry so in_ready can be a flop with no
// combinational dependence on out_ready. flush kills every held entry and
// the killed-entry count accumulates in a saturating counter.
// While the main entry is invalid the outputs present a bubble: PC 0,
// metadata 0 and BUBBLE_INSTR.

module if_id_skid_reg #(
    parameter int                  PC_W         = 32,
    parameter int                  INSTR_W      = 32,
    parameter int                  META_W       = 26,
    parameter int                  SKID         = 1,
    parameter logic [INSTR_W-1:0]  BUBBLE_INSTR = 32'h0000_0013,
    parameter int                  CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [META_W-1:0]  in_meta,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [META_W-1:0]  out_meta,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   squash_cnt
);

    // Saturating add of the number of squashed entries (0..2) to the counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, a} + {{CNT_W{1'b0}}, b};
        if (sum > {2'b00, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Main entry M (drives the outputs) and skid entry S.
    logic               m_valid_q, m_valid_d;
    logic [PC_W-1:0]    m_pc_q,    m_pc_d;
    logic [INSTR_W-1:0] m_instr_q, m_instr_d;
    logic [META_W-1:0]  m_meta_q,  m_meta_d;
    logic               s_valid_q, s_valid_d;
    logic [PC_W-1:0]    s_pc_q,    s_pc_d;
    logic [INSTR_W-1:0] s_instr_q, s_instr_d;
    logic [META_W-1:0]  s_meta_q,  s_meta_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;

    logic               in_fire_s;
    logic               out_fire_s;
    logic [1:0]         occ_s;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = m_valid_q & out_ready;
    assign occ_s      = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    // Next-state for both entries and the squash counter; flush wins over all.
    always_comb begin
        m_valid_d = m_valid_q;
        m_pc_d    = m_pc_q;
        m_instr_d = m_instr_q;
        m_meta_d  = m_meta_q;
        s_valid_d = s_valid_q;
        s_pc_d    = s_pc_q;
        s_instr_d = s_instr_q;
        s_meta_d  = s_meta_q;
        cnt_d     = cnt_q;
        if (flush) begin
            // Drop everything, including any input offered this cycle.
            m_valid_d = 1'b0;
            m_pc_d    = {PC_W{1'b0}};
            m_instr_d = BUBBLE_INSTR;
            m_meta_d  = {META_W{1'b0}};
            s_valid_d = 1'b0;
            cnt_d     = sat_add(cnt_q, occ_s);
        end else begin
            case ({s_valid_q, m_valid_q})
                2'b00: begin
                    // EMPTY: a new entry goes straight to M.
                    if (in_fire_s) begin
                        m_valid_d = 1'b1;
                        m_pc_d    = in_pc;
                        m_instr_d = in_instr;
                        m_meta_d  = in_meta;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end
                2'b01: begin
                    // ONE: replace, drain, or park the newcomer in S.
                    if (in_fire_s && out_fire_s) begin
                        m_pc_d    = in_pc;
                        m_instr_d = in_instr;
                        m_meta_d  = in_meta;
                    end else if (out_fire_s) begin
                        m_valid_d = 1'b0;
                        m_pc_d    = {PC_W{1'b0}};
                        m_instr_d = BUBBLE_INSTR;
                        m_meta_d  = {META_W{1'b0}};
                    end else if (in_fire_s && (SKID != 0)) begin
                        s_valid_d = 1'b1;
                        s_pc_d    = in_pc;
                        s_instr_d = in_instr;
                        s_meta_d  = in_meta;
                    end else begin
                        m_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    // FULL: input is blocked; S moves up when M drains.
                    if (out_fire_s) begin
                        m_pc_d    = s_pc_q;
                        m_instr_d = s_instr_q;
                        m_meta_d  = s_meta_q;
                        s_valid_d = 1'b0;
                    end else begin
                        s_valid_d = 1'b1;
                    end
                end
                default: begin
                    // S valid without M cannot occur; recover to EMPTY.
                    m_valid_d = 1'b0;
                    m_pc_d    = {PC_W{1'b0}};
                    m_instr_d = BUBBLE_INSTR;
                    m_meta_d  = {META_W{1'b0}};
                    s_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Entry and counter state; reset leaves the outputs showing a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_q <= 1'b0;
            m_pc_q    <= {PC_W{1'b0}};
            m_instr_q <= BUBBLE_INSTR;
            m_meta_q  <= {META_W{1'b0}};
            s_valid_q <= 1'b0;
            s_pc_q    <= {PC_W{1'b0}};
            s_instr_q <= {INSTR_W{1'b0}};
            s_meta_q  <= {META_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            m_valid_q <= m_valid_d;
            m_pc_q    <= m_pc_d;
            m_instr_q <= m_instr_d;
            m_meta_q  <= m_meta_d;
            s_valid_q <= s_valid_d;
            s_pc_q    <= s_pc_d;
            s_instr_q <= s_instr_d;
            s_meta_q  <= s_meta_d;
            cnt_q     <= cnt_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            // Registered ready: open whenever the skid slot will be free.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= ~s_valid_d;
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = ~m_valid_q | out_ready;
        end
    endgenerate

    assign out_valid  = m_valid_q;
    assign out_pc     = m_pc_q;
    assign out_instr  = m_instr_q;
    assign out_meta   = m_meta_q;
    assign occupancy  = occ_s;
    assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench: a vector table for the SKID=1 / CNT_W=2 instance plus
// hand sequences for the SKID=0 instance and asynchronous reset.

module tb_if_id_skid_reg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // SKID=1, CNT_W=2 instance
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_pc, a_in_instr, a_out_pc, a_out_instr;
    logic [25:0] a_in_meta, a_out_meta;
    logic [1:0]  a_occ;
    logic [1:0]  a_sq;

    // SKID=0, CNT_W=16 instance
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_pc, b_in_instr, b_out_pc, b_out_instr;
    logic [25:0] b_in_meta, b_out_meta;
    logic [1:0]  b_occ;
    logic [15:0] b_sq;

    if_id_skid_reg #(.SKID(1), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_pc(a_in_pc), .in_instr(a_in_instr), .in_meta(a_in_meta),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pc(a_out_pc), .out_instr(a_out_instr), .out_meta(a_out_meta),
        .occupancy(a_occ), .squash_cnt(a_sq)
    );

    if_id_skid_reg #(.SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_pc(b_in_pc), .in_instr(b_in_instr), .in_meta(b_in_meta),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_instr(b_out_instr), .out_meta(b_out_meta),
        .occupancy(b_occ), .squash_cnt(b_sq)
    );

    int n_pass = 0;
    int n_tot  = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    function automatic logic [25:0] meta_of(input logic [31:0] pc);
        return pc[25:0] ^ 26'h2AA_AAAA;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        logic [1:0]  eocc;
        logic        eir;
        logic [1:0]  esq;
    } vec_t;

    vec_t tbl[$];

    function automatic void pu(input logic iv, input logic [31:0] pc, input logic ordy,
                               input logic fl, input logic ev, input logic [31:0] epc,
                               input logic [1:0] eocc, input logic eir, input logic [1:0] esq);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.epc = epc; v.eocc = eocc; v.eir = eir; v.esq = esq;
        tbl.push_back(v);
    endfunction

    task automatic drive_a(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        a_in_valid  = iv;
        a_in_pc     = pc;
        a_in_instr  = instr_of(pc);
        a_in_meta   = meta_of(pc);
        a_out_ready = ordy;
        a_flush     = fl;
    endtask

    task automatic drive_b(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        b_in_valid  = iv;
        b_in_pc     = pc;
        b_in_instr  = instr_of(pc);
        b_in_meta   = meta_of(pc);
        b_out_ready = ordy;
        b_flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stream 8 entries at full rate.
        for (int k = 0; k < 8; k++) begin
            pu(1'b1, 32'(4 * k), 1'b1, 1'b0, 1'b1, 32'(4 * k), 2'd1, 1'b1, 2'd0);
        end
        // Skid: hold 0x100, stall with 0x104 offered, then drain in order.
        pu(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 2'd1, 1'b1, 2'd0);
        pu(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 32'h100, 2'd2, 1'b0, 2'd0);
        pu(1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100, 2'd2, 1'b0, 2'd0);
        pu(1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h104, 2'd1, 1'b1, 2'd0);
        pu(1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   2'd0, 1'b1, 2'd0);
        // FULL then flush with 0x200 offered.
        pu(1'b1, 32'h1F8, 1'b0, 1'b0, 1'b1, 32'h1F8, 2'd1, 1'b1, 2'd0);
        pu(1'b1, 32'h1FC, 1'b0, 1'b0, 1'b1, 32'h1F8, 2'd2, 1'b0, 2'd0);
        pu(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0,   2'd0, 1'b1, 2'd2);
        pu(1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   2'd0, 1'b1, 2'd2);
        // Two more full flushes: 2+2 saturates at 3, stays at 3.
        pu(1'b1, 32'h210, 1'b0, 1'b0, 1'b1, 32'h210, 2'd1, 1'b1, 2'd2);
        pu(1'b1, 32'h214, 1'b0, 1'b0, 1'b1, 32'h210, 2'd2, 1'b0, 2'd2);
        pu(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   2'd0, 1'b1, 2'd3);
        pu(1'b1, 32'h220, 1'b0, 1'b0, 1'b1, 32'h220, 2'd1, 1'b1, 2'd3);
        pu(1'b1, 32'h224, 1'b0, 1'b0, 1'b1, 32'h220, 2'd2, 1'b0, 2'd3);
        pu(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   2'd0, 1'b1, 2'd3);

        reset = 1'b0;
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        drive_b(1'b0, 32'h0, 1'b0, 1'b0);
        #22;
        chk("rst a out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst a out_pc", {32'd0, a_out_pc}, 64'd0);
        chk("rst a out_instr", {32'd0, a_out_instr}, 64'h13);
        chk("rst a out_meta", {38'd0, a_out_meta}, 64'd0);
        chk("rst a occupancy", {62'd0, a_occ}, 64'd0);
        chk("rst a squash_cnt", {62'd0, a_sq}, 64'd0);
        chk("rst a in_ready", {63'd0, a_in_ready}, 64'd1);
        chk("rst b in_ready", {63'd0, b_in_ready}, 64'd1);
        chk("rst b squash_cnt", {48'd0, b_sq}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive_a(tbl[i].iv, tbl[i].pc, tbl[i].ordy, tbl[i].fl);
            step();
            chk($sformatf("row%0d out_valid", i), {63'd0, a_out_valid}, {63'd0, tbl[i].ev});
            chk($sformatf("row%0d out_pc", i), {32'd0, a_out_pc}, {32'd0, tbl[i].epc});
            chk($sformatf("row%0d out_instr", i), {32'd0, a_out_instr},
                {32'd0, (tbl[i].ev ? instr_of(tbl[i].epc) : 32'h0000_0013)});
            chk($sformatf("row%0d out_meta", i), {38'd0, a_out_meta},
                {38'd0, (tbl[i].ev ? meta_of(tbl[i].epc) : 26'd0)});
            chk($sformatf("row%0d occupancy", i), {62'd0, a_occ}, {62'd0, tbl[i].eocc});
            chk($sformatf("row%0d in_ready", i), {63'd0, a_in_ready}, {63'd0, tbl[i].eir});
            chk($sformatf("row%0d squash_cnt", i), {62'd0, a_sq}, {62'd0, tbl[i].esq});
        end
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);

        // SKID=0: combinational in_ready and simultaneous replacement.
        drive_b(1'b1, 32'h300, 1'b1, 1'b0);
        #1;
        chk("b empty in_ready", {63'd0, b_in_ready}, 64'd1);
        step();
        chk("b load out_pc", {32'd0, b_out_pc}, 64'h300);
        chk("b load occupancy", {62'd0, b_occ}, 64'd1);
        drive_b(1'b1, 32'h304, 1'b0, 1'b0);
        #1;
        chk("b stall in_ready", {63'd0, b_in_ready}, 64'd0);
        step();
        chk("b stall out_pc", {32'd0, b_out_pc}, 64'h300);
        chk("b stall occupancy", {62'd0, b_occ}, 64'd1);
        b_out_ready = 1'b1;
        #1;
        chk("b resume in_ready", {63'd0, b_in_ready}, 64'd1);
        step();
        chk("b replace out_pc", {32'd0, b_out_pc}, 64'h304);
        chk("b replace out_instr", {32'd0, b_out_instr}, {32'd0, instr_of(32'h304)});
        chk("b replace out_meta", {38'd0, b_out_meta}, {38'd0, meta_of(32'h304)});
        drive_b(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        b_flush = 1'b0;
        chk("b flush out_valid", {63'd0, b_out_valid}, 64'd0);
        chk("b flush squash_cnt", {48'd0, b_sq}, 64'd1);
        chk("b flush in_ready", {63'd0, b_in_ready}, 64'd1);

        // Asynchronous reset while FULL.
        drive_a(1'b1, 32'h400, 1'b0, 1'b0);
        step();
        drive_a(1'b1, 32'h404, 1'b0, 1'b0);
        step();
        chk("ar full occupancy", {62'd0, a_occ}, 64'd2);
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk("ar out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("ar out_pc", {32'd0, a_out_pc}, 64'd0);
        chk("ar out_instr", {32'd0, a_out_instr}, 64'h13);
        chk("ar out_meta", {38'd0, a_out_meta}, 64'd0);
        chk("ar occupancy", {62'd0, a_occ}, 64'd0);
        chk("ar squash_cnt", {62'd0, a_sq}, 64'd0);
        chk("ar in_ready", {63'd0, a_in_ready}, 64'd1);
        chk("ar b squash_cnt", {48'd0, b_sq}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        a_out_ready = 1'b1;
        step();
        chk("post-rst out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("post-rst occupancy", {62'd0, a_occ}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
